// File: rtl/tx_dwidth_pkg.sv
// Shared types and elaboration helpers for the TX width down-converter.
// Word ordering is selected by TX_DWIDTH_CONV_LSB_FIRST_EN (see tx_word_sel).
package tx_dwidth_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int ratio(input int din_w, input int dout_w);
        return din_w / dout_w;
    endfunction

    function automatic int idx_w(input int r);
        return (r > 32'sd1) ? $clog2(r) : 32'sd1;
    endfunction

    // Bit position of the least-significant bit of word k inside a beat.
    function automatic int word_lsb(input int din_w, input int dout_w, input int k,
                                    input bit lsb_first);
        return lsb_first ? (k * dout_w) : (din_w - ((k + 32'sd1) * dout_w));
    endfunction

    function automatic int clamp_idx(input int idx, input int max_idx);
        return (idx > max_idx) ? max_idx : idx;
    endfunction

endpackage

// File: rtl/tx_word_sel.sv
// Combinational RATIO:1 word mux over the held beat.
// Ordering: MSB-first by default, LSB-first when TX_DWIDTH_CONV_LSB_FIRST_EN is defined.
module tx_word_sel
    import tx_dwidth_pkg::*;
#(
    parameter int DWIDTH_IN  = 256,
    parameter int DWIDTH_OUT = 64,
    parameter int RATIO      = 4,
    parameter int IDX_W      = 2
) (
    input  logic [DWIDTH_IN-1:0]  hreg,
    input  logic [IDX_W-1:0]      cnt,
    output logic [DWIDTH_OUT-1:0] word
);

`ifdef TX_DWIDTH_CONV_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic [DWIDTH_OUT-1:0] words_s [RATIO];

    for (genvar k = 0; k < RATIO; k++) begin : g_word
        assign words_s[k] = hreg[word_lsb(DWIDTH_IN, DWIDTH_OUT, k, LSB_FIRST) +: DWIDTH_OUT];
    end

    // AND-OR select avoids out-of-range indexing when RATIO is not a power of two
    always_comb begin
        word = '0;
        for (int k = 0; k < RATIO; k++) begin
            word = word | ((cnt == IDX_W'(k)) ? words_s[k] : '0);
        end
    end

endmodule

// File: rtl/tx_dwidth_conv_axis.sv
// TX width down-converter: one DWIDTH_IN beat out as RATIO DWIDTH_OUT words with
// valid/ready on both sides. Word order follows TX_DWIDTH_CONV_LSB_FIRST_EN.
module tx_dwidth_conv_axis
    import tx_dwidth_pkg::*;
#(
    parameter int  DWIDTH_IN  = 256,
    parameter int  DWIDTH_OUT = 64,
    localparam int RATIO      = ratio(DWIDTH_IN, DWIDTH_OUT),
    localparam int IDX_W      = idx_w(RATIO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DWIDTH_IN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_last,
    input  logic [IDX_W-1:0]      din_last_idx,
    output logic [DWIDTH_OUT-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sof,
    output logic                  dout_last
);

    if ((DWIDTH_IN < DWIDTH_OUT) || ((DWIDTH_IN % DWIDTH_OUT) != 32'sd0)) begin : g_width_chk
        $error("tx_dwidth_conv_axis: DWIDTH_IN must be an integer multiple of DWIDTH_OUT");
    end

    state_t                 state_r, state_s;
    logic [DWIDTH_IN-1:0]   hreg_r, hreg_s;
    logic [IDX_W-1:0]       cnt_r, cnt_s;
    logic [IDX_W-1:0]       lidx_r, lidx_s;
    logic                   lastflag_r, lastflag_s;
    logic [IDX_W-1:0]       end_idx_s;
    logic                   busy_s, final_s, load_s, drain_s;

    assign busy_s    = (state_r == ST_BUSY);
    assign end_idx_s = lastflag_r ? IDX_W'(clamp_idx(int'(lidx_r), RATIO - 32'sd1))
                                  : IDX_W'(RATIO - 32'sd1);
    assign final_s   = (cnt_r == end_idx_s);
    // Ready looks through dout_ready so the next beat loads as the final word drains
    assign din_ready = !busy_s || (dout_ready && final_s);
    assign load_s    = din_valid && din_ready;
    assign drain_s   = busy_s && dout_ready;

    // Next-state: a load wins over a plain drain in the same cycle
    always_comb begin
        state_s    = state_r;
        hreg_s     = hreg_r;
        cnt_s      = cnt_r;
        lastflag_s = lastflag_r;
        lidx_s     = lidx_r;
        if (load_s) begin
            state_s    = ST_BUSY;
            hreg_s     = din;
            cnt_s      = '0;
            lastflag_s = din_last;
            lidx_s     = din_last_idx;
        end else if (drain_s) begin
            if (final_s) begin
                state_s = ST_IDLE;
            end else begin
                cnt_s = cnt_r + IDX_W'(1);
            end
        end else begin
            state_s = state_r;
        end
    end

    // State register; reset discards any held beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hreg_r     <= '0;
            cnt_r      <= '0;
            lastflag_r <= 1'b0;
            lidx_r     <= '0;
        end else begin
            state_r    <= state_s;
            hreg_r     <= hreg_s;
            cnt_r      <= cnt_s;
            lastflag_r <= lastflag_s;
            lidx_r     <= lidx_s;
        end
    end

    tx_word_sel #(
        .DWIDTH_IN  (DWIDTH_IN),
        .DWIDTH_OUT (DWIDTH_OUT),
        .RATIO      (RATIO),
        .IDX_W      (IDX_W)
    ) u_word_sel (
        .hreg (hreg_r),
        .cnt  (cnt_r),
        .word (dout)
    );

    assign dout_valid = busy_s;
    assign dout_sof   = busy_s && (cnt_r == '0);
    assign dout_last  = busy_s && lastflag_r && final_s;

endmodule

// File: tb/tb_tx_dwidth_conv_axis.sv
// Bench for tx_dwidth_conv_axis (256 -> 64): queue-based word model checked every cycle,
// plus directed literal checks. Honours TX_DWIDTH_CONV_LSB_FIRST_EN for word order.
module tb_tx_dwidth_conv_axis;

    localparam int RATIO = 4;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;

    logic         clk, rst;
    logic [255:0] din;
    logic         din_valid, din_ready, din_last;
    logic [1:0]   din_last_idx;
    logic [63:0]  dout;
    logic         dout_valid, dout_ready, dout_sof, dout_last;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [63:0] w; bit sof; bit last; } word_t;
    word_t exp_q[$];

    logic [63:0] t1_exp [4];
    logic [63:0] t4_next_w0, t5_next_w0;

    tx_dwidth_conv_axis #(.DWIDTH_IN(256), .DWIDTH_OUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .din_last     (din_last),
        .din_last_idx (din_last_idx),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_sof     (dout_sof),
        .dout_last    (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input logic [255:0] b, input int k);
`ifdef TX_DWIDTH_CONV_LSB_FIRST_EN
        return b[k*64 +: 64];
`else
        return b[255 - k*64 -: 64];
`endif
    endfunction

    // Model: queue of words still owed by the DUT; checked 2 ns before each rising edge
    always @(negedge clk) begin
        word_t e;
        bit    exp_ready;
        int    last_i;
        #3;
        if (rst) begin
            exp_q.delete();
            chk("rst_dout_valid", 64'(dout_valid), 64'd0);
            chk("rst_dout", dout, 64'd0);
            chk("rst_dout_sof", 64'(dout_sof), 64'd0);
            chk("rst_dout_last", 64'(dout_last), 64'd0);
        end else begin
            exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && dout_ready);
            chk("m_din_ready", 64'(din_ready), 64'(exp_ready));
            chk("m_dout_valid", 64'(dout_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("m_dout", dout, exp_q[0].w);
                chk("m_dout_sof", 64'(dout_sof), 64'(exp_q[0].sof));
                chk("m_dout_last", 64'(dout_last), 64'(exp_q[0].last));
                if (dout_ready) void'(exp_q.pop_front());
            end
            if (din_valid && exp_ready) begin
                last_i = din_last ? int'(din_last_idx) : RATIO - 1;
                if (last_i > RATIO - 1) last_i = RATIO - 1;
                for (int k = 0; k <= last_i; k++) begin
                    e.w    = beat_word(din, k);
                    e.sof  = (k == 0);
                    e.last = din_last && (k == last_i);
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [255:0] d, input logic l,
                         input logic [1:0] li, input logic r);
        @(negedge clk);
        din_valid    = v;
        din          = d;
        din_last     = l;
        din_last_idx = li;
        dout_ready   = r;
    endtask

    initial begin
        logic [255:0] beats [3];
        logic [15:0]  acc, vld;
        int           b;

`ifdef TX_DWIDTH_CONV_LSB_FIRST_EN
        t1_exp     = '{WD, WC, WB, WA};
        t4_next_w0 = WA;
        t5_next_w0 = WC;
`else
        t1_exp     = '{WA, WB, WC, WD};
        t4_next_w0 = WD;
        t5_next_w0 = WB;
`endif
        rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
        din_last_idx = '0; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1 / 6: single beat, four words, sof on first, din_ready only on the last
        drive(1'b1, {WA, WB, WC, WD}, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
            #4;
            chk($sformatf("t1_word%0d", k), dout, t1_exp[k]);
            chk($sformatf("t1_sof%0d", k), 64'(dout_sof), 64'(k == 0));
            chk($sformatf("t1_rdy%0d", k), 64'(din_ready), 64'(k == 3));
        end
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4 chk("t1_idle_valid", 64'(dout_valid), 64'd0);

        // 2: three back-to-back beats, no bubbles
        beats = '{{WA, WB, WC, WD}, {WB, WC, WD, WA}, {WC, WD, WA, WB}};
        acc = '0; vld = '0; b = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            din_valid  = (b < 3);
            din        = (b < 3) ? beats[b] : '0;
            din_last   = 1'b0;
            dout_ready = 1'b1;
            #4;
            vld[c] = dout_valid;
            if (din_valid && din_ready) begin
                acc[c] = 1'b1;
                b++;
            end
        end
        chk("t2_accept_cycles", 64'(acc), 64'h0111);
        chk("t2_valid_cycles", 64'(vld), 64'h1FFE);

        // 3: backpressure while the second word is presented
        drive(1'b1, {WA, WB, WC, WD}, 1'b0, 2'd0, 1'b1);
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4 chk("t3_w0", dout, t1_exp[0]);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 2'd0, 1'b0);
            #4;
            chk($sformatf("t3_hold_w%0d", k), dout, t1_exp[1]);
            chk($sformatf("t3_hold_sof%0d", k), 64'(dout_sof), 64'd0);
            chk($sformatf("t3_hold_rdy%0d", k), 64'(din_ready), 64'd0);
        end
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4 chk("t3_resume_w1", dout, t1_exp[1]);
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4 chk("t3_resume_w2", dout, t1_exp[2]);
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4 chk("t3_resume_w3", dout, t1_exp[3]);

        // 4: partial last beat (two words) followed immediately by a full beat
        drive(1'b1, {WA, WB, WC, WD}, 1'b1, 2'd1, 1'b1);
        drive(1'b1, {WD, WC, WB, WA}, 1'b0, 2'd0, 1'b1);
        #4;
        chk("t4_w0", dout, t1_exp[0]);
        chk("t4_w0_last", 64'(dout_last), 64'd0);
        chk("t4_w0_rdy", 64'(din_ready), 64'd0);
        drive(1'b1, {WD, WC, WB, WA}, 1'b0, 2'd0, 1'b1);
        #4;
        chk("t4_w1", dout, t1_exp[1]);
        chk("t4_w1_last", 64'(dout_last), 64'd1);
        chk("t4_w1_rdy", 64'(din_ready), 64'd1);
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4;
        chk("t4_next_w0", dout, t4_next_w0);
        chk("t4_next_sof", 64'(dout_sof), 64'd1);
        repeat (4) drive(1'b0, '0, 1'b0, 2'd0, 1'b1);

        // 5: asynchronous reset while the third word is presented
        drive(1'b1, {WA, WB, WC, WD}, 1'b0, 2'd0, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(dout_valid), 64'd0);
        chk("t5_rst_dout", dout, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, {WB, WA, WD, WC}, 1'b0, 2'd0, 1'b1);
        drive(1'b0, '0, 1'b0, 2'd0, 1'b1);
        #4;
        chk("t5_new_w0", dout, t5_next_w0);
        chk("t5_new_sof", 64'(dout_sof), 64'd1);
        repeat (5) drive(1'b0, '0, 1'b0, 2'd0, 1'b1);

        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
